ram_loader: RTL and testbench
=============================

# ram_loader

Bus initiator for the 16 x 8 program/data RAM. It accepts a byte stream over a valid/ready handshake and writes it into consecutive RAM addresses. It can also read a RAM region back out as a byte stream. It sits beside the CPU on the shared 8-bit tri-state bus and owns the bus, address lines and RAM enables while `busy` is high; the CPU is held via `cpu_halt`.

## Interface
- `DATA_W`, 8, bus and RAM word width
- `ADDR_W`, 4, RAM address width; depth = 2**ADDR_W
- `clk`  in  1  single clock; RAM samples on posedge
- `rst`  in  1  asynchronous, active-high reset
- `start_load`  in  1  one-cycle request: begin load
- `start_dump`  in  1  one-cycle request: begin readback
- `len_m1`  in  ADDR_W  word count minus one, sampled at start
- `in_data`  in  DATA_W  load byte
- `in_valid`  in  1  load byte valid
- `in_ready`  out  1  loader accepts byte
- `out_data`  out  DATA_W  dumped byte
- `out_valid`  out  1  dumped byte valid
- `out_ready`  in  1  consumer accepts byte
- `bus`  inout  DATA_W  shared tri-state data bus
- `addr`  out  ADDR_W  RAM address
- `ram_wr_en`, `ram_rd_en`  out  1  RAM enables, active high
- `busy`, `cpu_halt`  out  1  operation in progress (identical signals)
- `done`  out  1  one-cycle pulse at completion
- `err`  out  1  verify mismatch, sticky (only with macro)

## Operation
- States: IDLE, LOAD_WAIT, LOAD_WR, DUMP_RD, DUMP_OUT, VERIFY_RD (macro only), DONE.
- IDLE behaviour:
  - `start_load` -> LOAD_WAIT.
  - `start_dump` -> DUMP_RD.
  - Both asserted together: load wins.
  - Entering either operation clears the address pointer `ptr` to 0 and latches `len_m1` into `cnt`.
  - Starts outside IDLE are ignored.
- LOAD_WAIT:
  - `in_ready`=1.
  - On `in_valid && in_ready`, capture `in_data` into the data register -> LOAD_WR.
- LOAD_WR:
  - Drive `bus` = data register, `addr` = `ptr`, `ram_wr_en` = 1, `in_ready` = 0, for exactly one cycle.
  - If `ptr == cnt` -> DONE (VERIFY_RD with macro, `ptr` reset to 0); else increment `ptr` -> LOAD_WAIT.
- DUMP_RD:
  - `ram_rd_en` = 1 and `addr` = `ptr` for one cycle; the loader does not drive the bus.
  - Register `bus` into `out_data` at the end of the cycle -> DUMP_OUT.
- DUMP_OUT:
  - `out_valid` = 1; `out_data` is held stable until `out_ready`.
  - On handshake: if `ptr == cnt` -> DONE; else increment `ptr` -> DUMP_RD.
- DONE: `done` = 1 for one cycle -> IDLE.
- Bus ownership rules:
  - The loader drives `bus` only in LOAD_WR; it is high-Z in all other states.
  - `ram_wr_en` and `ram_rd_en` are never high in the same cycle.
- `ptr` is ADDR_W wide. `len_m1` = 2**ADDR_W-1 covers the full RAM with no wrap; `ptr` never exceeds `cnt`.

## Timing
- Reset values:
  - `in_ready`, `out_valid`, `ram_wr_en`, `ram_rd_en`, `busy`, `cpu_halt`, `done`, `err` = 0.
  - `addr`, `out_data` = 0.
  - `bus` = high-Z.
  - State = IDLE.
- Reset mid-operation: immediate return to IDLE and bus released. RAM contents already written stay as written; no rollback.
- `busy` rises the cycle after the accepted start and falls when DONE is entered. `done` is high in the cycle after `busy` falls.
- Load throughput: 2 cycles per byte minimum (LOAD_WAIT + LOAD_WR). A byte accepted in cycle N is written at the posedge ending cycle N+1.
- Dump: `out_valid` rises 2 cycles after the start is accepted. Throughput is 2 cycles per byte minimum.
- `in_ready` is a registered state decode; there is no combinational path from `in_valid` to `in_ready`.

## Configuration
- `RAM_LOADER_VERIFY_EN` defined:
  - During load, a running XOR checksum of accepted bytes is kept.
  - After the last write, VERIFY_RD reads addresses 0..`cnt` (one cycle each, `ram_rd_en` = 1) and XORs the returned bytes.
  - On completion, `err` is set if the two checksums differ, then DONE is entered.
  - `err` clears on the next accepted start.
- Not defined: no VERIFY_RD state, no checksum logic; `err` is tied 0; load goes straight from the last LOAD_WR to DONE.

## Structure
- Shared package: state enum `loader_state_t`, plus the `DATA_W`/`ADDR_W` defaults and depth constant shared with the RAM.
- Sub-module `ram_loader_cksum`: XOR accumulator with clear/enable, instantiated only under the macro.
- FSM, pointer and tri-state driver stay in `ram_loader`.

## Test plan
- Load 16 bytes 0x10..0x1F, `len_m1`=15, `in_valid` held high -> RAM[i]=0x10+i; one write every 2 cycles; single `done` pulse; `busy` low after.
- Load 3 bytes with `in_valid` gaps of 0/3/7 cycles -> only RAM[0..2] written; RAM[3] unchanged; no write while `in_valid` is low.
- Dump `len_m1`=15 after load with `out_ready` toggling 1/0 -> exactly 16 beats 0x10..0x1F in order; `out_data` stable while stalled.
- `start_load` and `start_dump` in the same cycle -> load runs; a `start_dump` pulsed while busy is ignored; the bus is never driven in the same cycle as `ram_rd_en`.
- Assert `rst` in LOAD_WR of byte 5 -> next edge: bus high-Z, all enables 0, IDLE; RAM[0..4] retained.
- With macro: after load, force RAM[2] via backdoor before VERIFY_RD -> `err`=1 with `done`; the next clean load clears `err` to 0.

Source files
------------

// File: rtl/ram_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_loader_pkg                                                |
// | Description : Shared types and constants for the RAM loader and the         |
// |               16 x 8 program/data RAM it initiates transfers to.            |
// |               Optional feature macro: RAM_LOADER_VERIFY_EN                  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package ram_loader_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int RAM_DEPTH  = 1 << ADDR_W_DEF;

  // Encodings are pinned so the verify state can be compiled out without
  // shifting the other codes.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_WAIT = 3'd1,
    LOAD_WR   = 3'd2,
    DUMP_RD   = 3'd3,
    DUMP_OUT  = 3'd4,
`ifdef RAM_LOADER_VERIFY_EN
    VERIFY_RD = 3'd5,
`endif
    DONE      = 3'd6
  } loader_state_t;

  // The loader owns the bus in every state except IDLE and DONE.
  function automatic logic state_busy(input loader_state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_loader_cksum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_loader_cksum                                              |
// | Description : XOR accumulator with synchronous clear and enable. Used in    |
// |               pairs by ram_loader to compare loaded vs. read-back data.     |
// |               Only instantiated when RAM_LOADER_VERIFY_EN is defined.       |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module ram_loader_cksum #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum
);

  // Clear has priority so a new operation never inherits an old checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum ^ din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_loader                                                    |
// | Description : Bus initiator for the 16 x 8 RAM. Loads a valid/ready byte    |
// |               stream into consecutive addresses, or dumps a region back     |
// |               out as a byte stream. Owns the shared tri-state bus while     |
// |               busy and halts the CPU.                                       |
// |               Optional feature macro: RAM_LOADER_VERIFY_EN (post-load       |
// |               read-back XOR verification with sticky err flag).             |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic [ADDR_W-1:0] len_m1,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  inout  wire  [DATA_W-1:0] bus,
  output logic [ADDR_W-1:0] addr,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  output logic              busy,
  output logic              cpu_halt,
  output logic              done,
  output logic              err
);

  loader_state_t     state;
  loader_state_t     state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] data_reg;
  logic              bus_drive;
  logic              start_acc;
  logic              accept;
  logic              last;

  // A start is only honoured from IDLE; requests in any other state are dropped.
  assign start_acc = (state == IDLE) && (start_load || start_dump);
  // in_ready is a pure decode of the state register, so accept never loops
  // combinationally back from in_valid to in_ready.
  assign accept    = (state == LOAD_WAIT) && in_valid;
  assign last      = (ptr == cnt);

  assign busy      = state_busy(state);
  assign cpu_halt  = busy;

  // Tri-state driver: the bus is only ours during the single write cycle.
  assign bus = bus_drive ? data_reg : {DATA_W{1'bz}};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded bus/handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    ram_wr_en = 1'b0;
    ram_rd_en = 1'b0;
    addr      = '0;
    done      = 1'b0;
    bus_drive = 1'b0;
    case (state)
      IDLE: begin
        // Load wins when both starts arrive together.
        if (start_load) begin
          state_nxt = LOAD_WAIT;
        end else if (start_dump) begin
          state_nxt = DUMP_RD;
        end
      end
      LOAD_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = LOAD_WR;
        end
      end
      LOAD_WR: begin
        bus_drive = 1'b1;
        addr      = ptr;
        ram_wr_en = 1'b1;
        if (last) begin
`ifdef RAM_LOADER_VERIFY_EN
          state_nxt = VERIFY_RD;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = LOAD_WAIT;
        end
      end
      DUMP_RD: begin
        ram_rd_en = 1'b1;
        addr      = ptr;
        state_nxt = DUMP_OUT;
      end
      DUMP_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = last ? DONE : DUMP_RD;
        end
      end
`ifdef RAM_LOADER_VERIFY_EN
      VERIFY_RD: begin
        ram_rd_en = 1'b1;
        addr      = ptr;
        if (last) begin
          state_nxt = DONE;
        end
      end
`endif
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Address pointer, length, write data and read data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      cnt      <= '0;
      data_reg <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_acc) begin
            ptr <= '0;
            cnt <= len_m1;
          end
        end
        LOAD_WAIT: begin
          if (accept) begin
            data_reg <= in_data;
          end
        end
        LOAD_WR: begin
          if (!last) begin
            ptr <= ptr + ADDR_W'(1);
          end else begin
            // Rewind so the read-back pass (when present) starts at 0.
            ptr <= '0;
          end
        end
        DUMP_RD: begin
          // The RAM drives the bus during this cycle; capture it at the edge.
          out_data <= bus;
        end
        DUMP_OUT: begin
          if (out_ready && !last) begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
`ifdef RAM_LOADER_VERIFY_EN
        VERIFY_RD: begin
          if (!last) begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

`ifdef RAM_LOADER_VERIFY_EN
  logic [DATA_W-1:0] load_sum;
  logic [DATA_W-1:0] read_sum;
  logic              verify_rd;

  assign verify_rd = (state == VERIFY_RD);

  ram_loader_cksum #(
    .DATA_W (DATA_W)
  ) u_load_cksum (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .en  (accept),
    .din (in_data),
    .sum (load_sum)
  );

  ram_loader_cksum #(
    .DATA_W (DATA_W)
  ) u_read_cksum (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .en  (verify_rd),
    .din (bus),
    .sum (read_sum)
  );

  // Sticky mismatch flag; the last read byte is folded in combinationally so
  // the decision is made in the same cycle that DONE is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (start_acc) begin
      err <= 1'b0;
    end else if (verify_rd && last && ((read_sum ^ bus) != load_sum)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ram_loader                                                 |
// | Description : Self-checking bench for ram_loader with a behavioural 16x8    |
// |               RAM on a pulled-up tri-state bus, write/beat scoreboards and  |
// |               a table of load/dump operations.                              |
// |               Optional feature macro: RAM_LOADER_VERIFY_EN                  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ram_loader;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef struct {
    bit            is_load;
    bit            both;
    bit            poke;
    bit            corrupt;
    bit            toggle;
    bit            chk_lat;
    logic [AW-1:0] len_m1;
    logic [DW-1:0] base;
    int            g1;
    int            g2;
  } op_t;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          start_load = 1'b0;
  logic          start_dump = 1'b0;
  logic [AW-1:0] len_m1     = '0;
  logic [DW-1:0] in_data    = '0;
  logic          in_valid   = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready  = 1'b1;
  tri1  [DW-1:0] bus;
  logic [AW-1:0] addr;
  logic          ram_wr_en;
  logic          ram_rd_en;
  logic          busy;
  logic          cpu_halt;
  logic          done;
  logic          err;

  ram_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_load (start_load),
    .start_dump (start_dump),
    .len_m1     (len_m1),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .bus        (bus),
    .addr       (addr),
    .ram_wr_en  (ram_wr_en),
    .ram_rd_en  (ram_rd_en),
    .busy       (busy),
    .cpu_halt   (cpu_halt),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: asynchronous read onto the bus, write on posedge.
  logic [DW-1:0] mem     [DEPTH] = '{default: 8'h00};
  logic [DW-1:0] ref_mem [DEPTH] = '{default: 8'h00};
  logic          bd_en   = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  assign bus = ram_rd_en ? mem[addr] : {DW{1'bz}};

  always @(posedge clk) begin
    if (ram_wr_en) mem[addr] <= bus;
    if (bd_en) mem[bd_addr] <= bd_data;
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboards
  logic [AW+DW-1:0] wq[$];
  logic [DW-1:0]    bq[$];
  logic [AW+DW-1:0] w_exp;
  logic [DW-1:0]    b_exp;
  logic [DW-1:0]    held;
  logic             hold_v    = 1'b0;
  int               done_cnt  = 0;
  int               done_cyc  = 0;
  int               done_err  = 0;
  int               first_ov  = -1;
  int               beat_cnt  = 0;
  bit               ready_mode = 1'b0;

  // Consumer ready: constant high or toggling every cycle.
  always begin
    @(posedge clk);
    #1;
    out_ready = ready_mode ? ~out_ready : 1'b1;
  end

  // Mid-cycle bus/handshake monitor
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (ram_wr_en) begin
        chk("wr_rd_exclusive", int'(ram_rd_en), 0);
        if (wq.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          w_exp = wq.pop_front();
          chk("write_addr_data", int'({addr, bus}), int'(w_exp));
        end
      end
      if (ram_rd_en) chk("read_bus_clean", int'(bus), int'(mem[addr]));
      if (!ram_wr_en && !ram_rd_en) chk("bus_released", int'(bus), 8'hFF);
      if (out_valid) begin
        if (first_ov < 0) first_ov = cyc;
        if (hold_v) chk("out_data_stable", int'(out_data), int'(held));
        if (out_ready) begin
          beat_cnt++;
          hold_v = 1'b0;
          if (bq.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            b_exp = bq.pop_front();
            chk("beat_data", int'(out_data), int'(b_exp));
          end
        end else begin
          hold_v = 1'b1;
          held   = out_data;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = int'(err);
      end
    end
  end

  // Cycle index (start cycle = 0) at which DONE is expected with no stalls.
  function automatic int exp_lat(input bit is_load, input int n);
`ifdef RAM_LOADER_VERIFY_EN
    return is_load ? 3 * n + 1 : 2 * n + 1;
`else
    return 2 * n + 1;
`endif
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic run_op(input op_t o);
    int n;
    int s;
    int gap;
    int t;
    n        = int'(o.len_m1) + 1;
    done_cnt = 0;
    beat_cnt = 0;
    first_ov = -1;
    done_err = 0;
    ready_mode = o.toggle;
    if (!o.is_load) begin
      for (int i = 0; i < n; i++) bq.push_back(ref_mem[i]);
    end
    @(posedge clk);
    #1;
    start_load = o.is_load;
    start_dump = !o.is_load || o.both;
    len_m1     = o.len_m1;
    @(posedge clk);
    #1;
    start_load = 1'b0;
    start_dump = 1'b0;
    s = cyc;
    chk("busy_after_start", int'(busy), 1);
    chk("cpu_halt_after_start", int'(cpu_halt), 1);
    if (o.is_load) begin
      for (int i = 0; i < n; i++) begin
        gap = (i == 0) ? 0 : ((i == 1) ? o.g1 : o.g2);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
        in_data  = o.base + DW'(i);
        in_valid = 1'b1;
        wq.push_back({AW'(i), in_data});
        ref_mem[i] = in_data;
        wait_ready();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (o.corrupt && i == n - 1) begin
          bd_addr    = 4'd2;
          bd_data    = 8'h99;
          bd_en      = 1'b1;
          ref_mem[2] = 8'h99;
          @(posedge clk);
          #1;
          bd_en = 1'b0;
        end
        if (o.poke && i == 0) begin
          start_dump = 1'b1;
          @(posedge clk);
          #1;
          start_dump = 1'b0;
        end
      end
    end
    t = 0;
    while (done_cnt == 0 && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("busy_after_done", int'(busy), 0);
    chk("err_at_done", done_err, int'(o.corrupt));
    chk("err_after_done", int'(err), int'(o.corrupt));
    if (o.chk_lat) chk("done_latency", done_cyc - s + 1, exp_lat(o.is_load, n));
    if (!o.is_load) begin
      chk("beat_count", beat_cnt, n);
      if (o.chk_lat) chk("first_valid_latency", first_ov - s + 1, 2);
    end
    chk("write_queue_drained", wq.size(), 0);
    chk("beat_queue_drained", bq.size(), 0);
    if (o.is_load) begin
      for (int j = 0; j < DEPTH; j++) chk("ram_contents", int'(mem[j]), int'(ref_mem[j]));
    end
    ready_mode = 1'b0;
  endtask

  // Reset asserted during the write cycle of byte 5 of a 16-byte load.
  task automatic reset_mid();
    @(posedge clk);
    #1;
    start_load = 1'b1;
    len_m1     = 4'd15;
    @(posedge clk);
    #1;
    start_load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_data  = 8'h50 + DW'(i);
      in_valid = 1'b1;
      if (i < 5) begin
        wq.push_back({AW'(i), in_data});
        ref_mem[i] = in_data;
      end
      wait_ready();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    chk("mid_in_load_wr", int'(ram_wr_en), 1);
    chk("mid_addr_5", int'(addr), 5);
    rst = 1'b1;
    #1;
    chk("rst_bus_released", int'(bus), 8'hFF);
    chk("rst_wr_en", int'(ram_wr_en), 0);
    chk("rst_rd_en", int'(ram_rd_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_addr", int'(addr), 0);
    @(posedge clk);
    #1;
    chk("rst_edge_bus", int'(bus), 8'hFF);
    chk("rst_edge_busy", int'(busy), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_after_rst", int'(busy), 0);
    for (int j = 0; j < DEPTH; j++) chk("ram_retained", int'(mem[j]), int'(ref_mem[j]));
    chk("mid_write_queue", wq.size(), 0);
  endtask

  initial begin
    op_t ops[5];
    op_t fin;
    //          load both poke corr togl lat  len    base   g1 g2
    ops[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 8'h10, 0, 0};
    ops[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 8'h00, 0, 0};
    ops[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2,  8'hA0, 3, 7};
    ops[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3,  8'h00, 0, 0};
    ops[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1,  8'h30, 0, 0};
    fin    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 8'h00, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_wr_en", int'(ram_wr_en), 0);
    chk("reset_rd_en", int'(ram_rd_en), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cpu_halt", int'(cpu_halt), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_addr", int'(addr), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_bus", int'(bus), 8'hFF);
    rst = 1'b0;

    for (int k = 0; k < 5; k++) run_op(ops[k]);
    reset_mid();
    run_op(fin);
`ifdef RAM_LOADER_VERIFY_EN
    fin = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 8'h60, 0, 0};
    run_op(fin);
    fin = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 8'h70, 0, 0};
    run_op(fin);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

endmodule
`default_nettype wire
